// File: rtl/cordic_vectoring_unit.sv
// rtl/cordic_vectoring_unit.sv - iterative CORDIC vectoring: atan2 angle and gain-corrected magnitude
module cordic_vectoring_unit #(
    parameter int ITERATIONS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] angle_out,
    output logic [31:0] mag_out,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;

    localparam logic [31:0] GAIN_INV = 32'h9B74_EDA8;

    state_t             state, state_next;
    logic [4:0]         iter_cnt;
    logic signed [34:0] x_reg, y_reg;
    logic signed [34:0] x_shift, y_shift;
    logic [31:0]        z_reg;
    logic               zero_flag;
    logic [31:0]        angle_reg, mag_reg;
    logic [65:0]        mag_prod;
    logic               unused_bits;

    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:  atan_lut = 32'h2000_0000;
            5'd1:  atan_lut = 32'h12E4_051E;
            5'd2:  atan_lut = 32'h09FB_385B;
            5'd3:  atan_lut = 32'h0511_11D4;
            5'd4:  atan_lut = 32'h028B_0D43;
            5'd5:  atan_lut = 32'h0145_D7E1;
            5'd6:  atan_lut = 32'h00A2_F61E;
            5'd7:  atan_lut = 32'h0051_7C55;
            5'd8:  atan_lut = 32'h0028_BE53;
            5'd9:  atan_lut = 32'h0014_5F2F;
            5'd10: atan_lut = 32'h000A_2F98;
            5'd11: atan_lut = 32'h0005_17CC;
            5'd12: atan_lut = 32'h0002_8BE6;
            5'd13: atan_lut = 32'h0001_45F3;
            5'd14: atan_lut = 32'h0000_A2FA;
            5'd15: atan_lut = 32'h0000_517D;
            5'd16: atan_lut = 32'h0000_28BE;
            5'd17: atan_lut = 32'h0000_145F;
            5'd18: atan_lut = 32'h0000_0A30;
            5'd19: atan_lut = 32'h0000_0518;
            5'd20: atan_lut = 32'h0000_028C;
            5'd21: atan_lut = 32'h0000_0146;
            5'd22: atan_lut = 32'h0000_00A3;
            5'd23: atan_lut = 32'h0000_0051;
            5'd24: atan_lut = 32'h0000_0029;
            5'd25: atan_lut = 32'h0000_0014;
            5'd26: atan_lut = 32'h0000_000A;
            5'd27: atan_lut = 32'h0000_0005;
            5'd28: atan_lut = 32'h0000_0003;
            5'd29: atan_lut = 32'h0000_0001;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign angle_out = angle_reg;
    assign mag_out   = mag_reg;

    assign x_shift  = x_reg >>> iter_cnt;
    assign y_shift  = y_reg >>> iter_cnt;
    // X is non-negative after PRE and only grows, so bits [33:0] carry the full value
    assign mag_prod = {32'd0, x_reg[33:0]} * {34'd0, GAIN_INV};
    assign unused_bits = ^{mag_prod[65:64], mag_prod[31:0], x_reg[34]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid && in_ready) state_next = PRE;
            PRE:  state_next = ITER;
            ITER: if (iter_cnt == 5'(ITERATIONS - 1)) state_next = POST;
            POST: state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_cnt  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            zero_flag <= 1'b0;
            angle_reg <= '0;
            mag_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= {{3{x_in[31]}}, x_in};
                        y_reg     <= {{3{y_in[31]}}, y_in};
                        zero_flag <= (x_in == 32'd0) && (y_in == 32'd0);
                    end
                end
                PRE: begin
                    // Left half-plane: rotate by 180 degrees so the iterations converge
                    if (x_reg[34]) begin
                        x_reg <= -x_reg;
                        y_reg <= -y_reg;
                        z_reg <= 32'h8000_0000;
                    end else begin
                        z_reg <= 32'h0000_0000;
                    end
                    iter_cnt <= '0;
                end
                ITER: begin
                    if (!y_reg[34]) begin
                        x_reg <= x_reg + y_shift;
                        y_reg <= y_reg - x_shift;
                        z_reg <= z_reg + atan_lut(iter_cnt);
                    end else begin
                        x_reg <= x_reg - y_shift;
                        y_reg <= y_reg + x_shift;
                        z_reg <= z_reg - atan_lut(iter_cnt);
                    end
                    iter_cnt <= iter_cnt + 5'd1;
                end
                POST: begin
                    // A zero vector would otherwise report the summed rotation angle
                    angle_reg <= zero_flag ? 32'd0 : z_reg;
                    mag_reg   <= zero_flag ? 32'd0 : mag_prod[63:32];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_unit.sv
// tb/tb_cordic_vectoring_unit.sv - directed checks of latency, angle/magnitude, backpressure and reset abort
module tb_cordic_vectoring_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] angle_out;
    logic [31:0] mag_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [31:0] held_angle, held_mag;

    cordic_vectoring_unit #(.ITERATIONS(30)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp_v,
                              input logic [31:0] tol);
        logic signed [31:0] d;
        logic [31:0]        ad;
        d  = $signed(obs - exp_v);
        ad = (d < 0) ? 32'(-d) : 32'(d);
        checks++;
        assert ((ad <= tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h tol=%0d", tag, obs, exp_v, tol);
        end
    endtask

    // Present a vector in IDLE and step past the accepting edge
    task automatic start_vector(input string tag, input logic [31:0] xv, input logic [31:0] yv);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x_in     = xv;
        y_in     = yv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_in     = $urandom;
        y_in     = $urandom;
    endtask

    // Cycle 1 is the period that starts at the accepting edge
    task automatic wait_result(output int n);
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_vector(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                              input logic [31:0] ea, input logic [31:0] em);
        int n;
        start_vector(tag, xv, yv);
        wait_result(n);
        check({tag, "_latency"}, 32'(n), 32'd33);
        check_near({tag, "_angle"}, angle_out, ea, 32'd16);
        check_near({tag, "_mag"}, mag_out, em, 32'd9 + (em >> 24));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = 32'd0;
        y_in      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_angle",     angle_out,          32'd0);
        check("rst_mag",       mag_out,            32'd0);

        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        run_vector("east",  32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000);
        run_vector("north", 32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        run_vector("west",  32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 32'h4000_0000);
        run_vector("ne",    32'h4000_0000, 32'h4000_0000, 32'h2000_0000, 32'h5A82_799A);
        run_vector("se",    32'h4000_0000, 32'hC000_0000, 32'hE000_0000, 32'h5A82_799A);
        run_vector("sw_max", 32'h8000_0000, 32'h8000_0000, 32'hA000_0000, 32'hB504_F334);

        start_vector("zero", 32'd0, 32'd0);
        wait_result(lat);
        check("zero_latency", 32'(lat), 32'd33);
        check("zero_angle", angle_out, 32'd0);
        check("zero_mag",   mag_out,   32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Backpressure: hold DONE while a second vector waits on in_valid
        start_vector("bp", 32'h4000_0000, 32'h4000_0000);
        wait_result(lat);
        check("bp_latency", 32'(lat), 32'd33);
        check_near("bp_angle", angle_out, 32'h2000_0000, 32'd16);
        held_angle = angle_out;
        held_mag   = mag_out;
        in_valid = 1'b1;
        x_in     = 32'h0000_0000;
        y_in     = 32'h4000_0000;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, in_ready},  32'd0);
            check("bp_hold_angle", angle_out, held_angle);
            check("bp_hold_mag",   mag_out,   held_mag);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_xfer_valid",    {31'd0, out_valid}, 32'd0);
        check("bp_xfer_in_ready", {31'd0, in_ready},  32'd1);
        check("bp_xfer_busy",     {31'd0, busy},      32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next_busy", {31'd0, busy}, 32'd1);
        wait_result(lat);
        check("bp_next_latency", 32'(lat), 32'd33);
        check_near("bp_next_angle", angle_out, 32'h4000_0000, 32'd16);
        check_near("bp_next_mag",   mag_out,   32'h4000_0000, 32'd72);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Abort in the middle of the iterations
        start_vector("abort", 32'h0000_0000, 32'h4000_0000);
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd0);
        check("abort_busy",      {31'd0, busy},      32'd0);
        check("abort_angle",     angle_out,          32'd0);
        check("abort_mag",       mag_out,            32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_idle_out_valid", {31'd0, out_valid}, 32'd0);
        run_vector("after_abort", 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h4000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
